// File: rtl/u_adder_vec_checker.sv
// rtl/u_adder_vec_checker.sv - stimulus-and-check stage around an N-bit unsigned adder
// Sweeps a/b as arithmetic sequences, compares the DUT sum to a golden sum, records the first failure.
module u_adder_vec_checker #(
   parameter int N           = 5,
   parameter int A_INIT      = 28,
   parameter int B_INIT      = 5,
   parameter int A_STEP      = 2,
   parameter int B_STEP      = 3,
   parameter int B_DIV       = 2,
   parameter int NUM_VECTORS = 50
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   output logic [N-1:0] a_out,
   output logic [N-1:0] b_out,
   input  logic [N:0]   sum_in,
   output logic         busy,
   output logic         done,
   output logic         pass,
   output logic [7:0]   err_count,
   output logic [15:0]  vec_count,
   output logic [N-1:0] first_err_a,
   output logic [N-1:0] first_err_b,
   output logic [N:0]   first_err_sum
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      CHECK  = 2'd2,
      DONE   = 2'd3
   } state_t;

   localparam logic [N-1:0] A_INIT_V = N'(A_INIT);
   localparam logic [N-1:0] B_INIT_V = N'(B_INIT);
   localparam logic [N-1:0] A_STEP_V = N'(A_STEP);
   localparam logic [N-1:0] B_STEP_V = N'(B_STEP);
   localparam logic [15:0]  DIV_LAST = 16'(B_DIV - 1);
   localparam logic [15:0]  LAST_VEC = 16'(NUM_VECTORS);

   state_t         state, state_n;
   logic [N-1:0]   a_n, b_n;
   logic [15:0]    div_q, div_n;
   logic [7:0]     err_n;
   logic [15:0]    vec_n, vec_inc;
   logic [N-1:0]   fa_n, fb_n;
   logic [N:0]     fs_n;
   logic           pass_n, busy_n, done_n;
   logic [N:0]     golden;
   logic           mismatch;

   always_comb begin
      golden   = {1'b0, a_out} + {1'b0, b_out};
      mismatch = (sum_in != golden);
      vec_inc  = vec_count + 16'd1;

      state_n = state;
      a_n     = a_out;
      b_n     = b_out;
      div_n   = div_q;
      err_n   = err_count;
      vec_n   = vec_count;
      fa_n    = first_err_a;
      fb_n    = first_err_b;
      fs_n    = first_err_sum;
      pass_n  = pass;

      case (state)
         IDLE, DONE: begin
            if (start) begin
               state_n = SETTLE;
               a_n     = A_INIT_V;
               b_n     = B_INIT_V;
               div_n   = '0;
               err_n   = '0;
               vec_n   = '0;
               fa_n    = '0;
               fb_n    = '0;
               fs_n    = '0;
               pass_n  = 1'b0;
            end
         end
         SETTLE: state_n = CHECK;
         CHECK: begin
            if (mismatch) begin
               if (err_count != 8'hFF) err_n = err_count + 8'd1;
               // err_count saturates rather than wraps, so zero reliably marks "no failure yet"
               if (err_count == 8'd0) begin
                  fa_n = a_out;
                  fb_n = b_out;
                  fs_n = sum_in;
               end
            end
            vec_n = vec_inc;
            a_n   = a_out + A_STEP_V;
            if (div_q == DIV_LAST) begin
               b_n   = b_out + B_STEP_V;
               div_n = '0;
            end else begin
               div_n = div_q + 16'd1;
            end
            if (vec_inc == LAST_VEC) begin
               state_n = DONE;
               pass_n  = (err_count == 8'd0) && !mismatch;
            end else begin
               state_n = SETTLE;
            end
         end
         default: state_n = IDLE;
      endcase

      busy_n = (state_n == SETTLE) || (state_n == CHECK);
      done_n = (state_n == DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         a_out         <= A_INIT_V;
         b_out         <= B_INIT_V;
         div_q         <= '0;
         err_count     <= '0;
         vec_count     <= '0;
         first_err_a   <= '0;
         first_err_b   <= '0;
         first_err_sum <= '0;
         pass          <= 1'b0;
         busy          <= 1'b0;
         done          <= 1'b0;
      end else begin
         state         <= state_n;
         a_out         <= a_n;
         b_out         <= b_n;
         div_q         <= div_n;
         err_count     <= err_n;
         vec_count     <= vec_n;
         first_err_a   <= fa_n;
         first_err_b   <= fb_n;
         first_err_sum <= fs_n;
         pass          <= pass_n;
         busy          <= busy_n;
         done          <= done_n;
      end
   end

endmodule

// File: tb/tb_u_adder_vec_checker.sv
// tb/tb_u_adder_vec_checker.sv - directed, table-driven bench for u_adder_vec_checker
// Four instances: correct adder, adder wrong at (0,8), stuck-at-0 adder, carry corner.
module tb_u_adder_vec_checker;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic [3:0] rst_v;
   logic [3:0] start_v;
   logic [3:0] done_v;

   logic [4:0]  a0, b0, a1, b1, a2, b2, a3, b3;
   logic [5:0]  s0, s1, s2, s3;
   logic        busy0, busy1, busy2, busy3;
   logic        done0, done1, done2, done3;
   logic        pass0, pass1, pass2, pass3;
   logic [7:0]  err0, err1, err2, err3;
   logic [15:0] vec0, vec1, vec2, vec3;
   logic [4:0]  fa0, fb0, fa1, fb1, fa2, fb2, fa3, fb3;
   logic [5:0]  fs0, fs1, fs2, fs3;

   assign s0 = {1'b0, a0} + {1'b0, b0};
   assign s1 = {1'b0, a1} + {1'b0, b1} + ((a1 == 5'd0 && b1 == 5'd8) ? 6'd1 : 6'd0);
   assign s2 = 6'd0;
   assign s3 = {1'b0, a3} + {1'b0, b3};
   assign done_v = {done3, done2, done1, done0};

   u_adder_vec_checker u0 (
      .clk(clk), .rst(rst_v[0]), .start(start_v[0]), .a_out(a0), .b_out(b0), .sum_in(s0),
      .busy(busy0), .done(done0), .pass(pass0), .err_count(err0), .vec_count(vec0),
      .first_err_a(fa0), .first_err_b(fb0), .first_err_sum(fs0));

   u_adder_vec_checker u1 (
      .clk(clk), .rst(rst_v[1]), .start(start_v[1]), .a_out(a1), .b_out(b1), .sum_in(s1),
      .busy(busy1), .done(done1), .pass(pass1), .err_count(err1), .vec_count(vec1),
      .first_err_a(fa1), .first_err_b(fb1), .first_err_sum(fs1));

   u_adder_vec_checker #(.NUM_VECTORS(300)) u2 (
      .clk(clk), .rst(rst_v[2]), .start(start_v[2]), .a_out(a2), .b_out(b2), .sum_in(s2),
      .busy(busy2), .done(done2), .pass(pass2), .err_count(err2), .vec_count(vec2),
      .first_err_a(fa2), .first_err_b(fb2), .first_err_sum(fs2));

   u_adder_vec_checker #(.A_INIT(31), .B_INIT(31), .NUM_VECTORS(1)) u3 (
      .clk(clk), .rst(rst_v[3]), .start(start_v[3]), .a_out(a3), .b_out(b3), .sum_in(s3),
      .busy(busy3), .done(done3), .pass(pass3), .err_count(err3), .vec_count(vec3),
      .first_err_a(fa3), .first_err_b(fb3), .first_err_sum(fs3));

   typedef struct {
      logic [4:0]  a;
      logic [4:0]  b;
      logic [15:0] vec;
   } vec_t;

   vec_t tbl [8];
   int   passed = 0;
   int   total  = 0;
   int   cyc;

   task automatic chk(input string nm, input longint act, input longint exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
   endtask

   // cyc counts posedges after the start edge; a vector k sits in CHECK after edge 2k+1
   task automatic run0(input bit do_tbl, input int restart_at, input int rst_at, output int c);
      start_v[0] = 1'b1;
      @(posedge clk); #1;
      start_v[0] = 1'b0;
      chk("start_a", a0, 28);
      chk("start_b", b0, 5);
      chk("start_vec", vec0, 0);
      chk("start_err", err0, 0);
      chk("start_done", done0, 0);
      chk("start_busy", busy0, 1);
      c = 0;
      while (!done0 && c < 300) begin
         @(posedge clk); #1;
         c++;
         if (do_tbl && (c % 2 == 1) && (c / 2 < 8)) begin
            chk($sformatf("tbl%0d_a", c / 2), a0, tbl[c / 2].a);
            chk($sformatf("tbl%0d_b", c / 2), b0, tbl[c / 2].b);
            chk($sformatf("tbl%0d_vec", c / 2), vec0, tbl[c / 2].vec);
         end
         if (c == restart_at - 1) start_v[0] = 1'b1;
         if (c == restart_at) start_v[0] = 1'b0;
         if (rst_at != 0 && c == rst_at - 1) begin
            chk("pre_rst_vec", vec0, 9);
            rst_v[0] = 1'b1;
         end
         if (rst_at != 0 && c == rst_at) begin
            rst_v[0] = 1'b0;
            break;
         end
      end
   endtask

   task automatic run_inst(input int idx, input int limit, output int c);
      start_v[idx] = 1'b1;
      @(posedge clk); #1;
      start_v[idx] = 1'b0;
      c = 0;
      while (!done_v[idx] && c < limit) begin
         @(posedge clk); #1;
         c++;
      end
      chk($sformatf("u%0d_done_seen", idx), done_v[idx], 1);
   endtask

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      tbl[0] = '{5'd28, 5'd5,  16'd0};
      tbl[1] = '{5'd30, 5'd5,  16'd1};
      tbl[2] = '{5'd0,  5'd8,  16'd2};
      tbl[3] = '{5'd2,  5'd8,  16'd3};
      tbl[4] = '{5'd4,  5'd11, 16'd4};
      tbl[5] = '{5'd6,  5'd11, 16'd5};
      tbl[6] = '{5'd8,  5'd14, 16'd6};
      tbl[7] = '{5'd10, 5'd14, 16'd7};

      rst_v   = 4'hF;
      start_v = 4'h0;
      repeat (3) @(posedge clk);
      #1;
      rst_v = 4'h0;

      chk("rst_a", a0, 28);
      chk("rst_b", b0, 5);
      chk("rst_busy", busy0, 0);
      chk("rst_done", done0, 0);
      chk("rst_pass", pass0, 0);
      chk("rst_err", err0, 0);
      chk("rst_vec", vec0, 0);
      chk("rst_fa", fa0, 0);
      chk("rst_fb", fb0, 0);
      chk("rst_fs", fs0, 0);

      // run 1: stray start at cycle 10 must not restart
      run0(1'b1, 10, 0, cyc);
      chk("run1_latency", cyc, 100);
      chk("run1_pass", pass0, 1);
      chk("run1_err", err0, 0);
      chk("run1_vec", vec0, 50);
      chk("run1_a_end", a0, 0);
      chk("run1_b_end", b0, 16);
      chk("run1_busy", busy0, 0);

      // run 2: start from DONE repeats run 1
      run0(1'b1, 0, 0, cyc);
      chk("run2_latency", cyc, 100);
      chk("run2_pass", pass0, 1);
      chk("run2_err", err0, 0);
      chk("run2_vec", vec0, 50);

      // run 3: reset at cycle 20 abandons the run
      run0(1'b0, 10, 20, cyc);
      chk("mid_rst_a", a0, 28);
      chk("mid_rst_b", b0, 5);
      chk("mid_rst_busy", busy0, 0);
      chk("mid_rst_done", done0, 0);
      chk("mid_rst_pass", pass0, 0);
      chk("mid_rst_err", err0, 0);
      chk("mid_rst_vec", vec0, 0);
      repeat (4) @(posedge clk);
      #1;
      chk("idle_hold_busy", busy0, 0);
      chk("idle_hold_done", done0, 0);

      // faulty at (0,8): only vector 2 of the run hits it
      for (int r = 0; r < 2; r++) begin
         run_inst(1, 200, cyc);
         chk($sformatf("flt%0d_latency", r), cyc, 100);
         chk($sformatf("flt%0d_pass", r), pass1, 0);
         chk($sformatf("flt%0d_err", r), err1, 1);
         chk($sformatf("flt%0d_fa", r), fa1, 0);
         chk($sformatf("flt%0d_fb", r), fb1, 8);
         chk($sformatf("flt%0d_fs", r), fs1, 9);
      end

      // stuck-at-0 over 300 vectors: count must saturate
      run_inst(2, 700, cyc);
      chk("stk_latency", cyc, 600);
      chk("stk_err_sat", err2, 255);
      chk("stk_pass", pass2, 0);
      chk("stk_vec", vec2, 300);
      chk("stk_fa", fa2, 28);
      chk("stk_fb", fb2, 5);
      chk("stk_fs", fs2, 0);

      // carry corner: 31 + 31 = 62 in a single-vector run
      run_inst(3, 20, cyc);
      chk("cry_latency", cyc, 2);
      chk("cry_pass", pass3, 1);
      chk("cry_err", err3, 0);
      chk("cry_vec", vec3, 1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/u_adder_vec_checker.md
Name: u_adder_vec_checker

Overview:
- Synthesizable stimulus-and-check stage wrapped around an N-bit unsigned adder (e.g. the 5-bit ripple-carry adder).
- Drives operand pairs a/b as arithmetic sequences, samples the adder's N+1-bit sum and compares it against an internal golden sum.
- Reports pass/fail, error count and the first failing vector, so adder variants can be self-checked in hardware or regression simulation without a behavioural bench.

Parameters:
N, 5, operand width; the DUT sum is N+1 bits.
A_INIT, 28, first value of a (mod 2^N).
B_INIT, 5, first value of b (mod 2^N).
A_STEP, 2, added to a after every vector, wrapping mod 2^N.
B_STEP, 3, added to b after every B_DIV-th vector, wrapping mod 2^N.
B_DIV, 2, vectors per b update; must be at least 1.
NUM_VECTORS, 50, vectors per run; 1..65535.

Ports:
clk  in  1  clock, all state updates on the rising edge.
rst  in  1  synchronous, active-high reset.
start  in  1  one-cycle run request, accepted only in IDLE or DONE.
a_out  out  N  operand a to the DUT.
b_out  out  N  operand b to the DUT.
sum_in  in  N+1  DUT sum, combinational from a_out/b_out.
busy  out  1  high in SETTLE and CHECK.
done  out  1  high in DONE.
pass  out  1  valid while done: 1 = zero mismatches.
err_count  out  8  mismatch count, saturating at 255.
vec_count  out  16  vectors checked in the current run.
first_err_a  out  N  a of the first mismatching vector.
first_err_b  out  N  b of the first mismatching vector.
first_err_sum  out  N+1  DUT sum of the first mismatching vector.

Behaviour:
- Reset:
  - State goes to IDLE.
  - a_out=A_INIT, b_out=B_INIT.
  - busy=0, done=0, pass=0, err_count=0, vec_count=0, all first_err_* = 0.
  - Reset has priority over every other event, including mid-run; a run in progress is abandoned with no partial done.
- States: IDLE, SETTLE, CHECK, DONE. All outputs are registered.
- IDLE/DONE with start=1:
  - Load a_out=A_INIT, b_out=B_INIT.
  - Clear err_count, vec_count, first_err_* and the internal b-divider count.
  - Set pass=0; go to SETTLE.
- start=0 in IDLE/DONE: hold. start in SETTLE/CHECK: ignored, no restart, no queuing.
- SETTLE: a_out/b_out are stable for one full cycle so the combinational DUT settles. Next state is always CHECK.
- CHECK:
  - Golden = zero-extend(a_out) + zero-extend(b_out), N+1 bits, carry included.
  - If sum_in != golden: err_count increments (saturates at 255, never wraps).
  - If it is the first mismatch of the run, capture a_out, b_out and sum_in into first_err_*.
  - vec_count increments.
  - a_out <= (a_out + A_STEP) mod 2^N.
  - b divider increments; when it reaches B_DIV: b_out <= (b_out + B_STEP) mod 2^N and the divider clears.
  - If vec_count (post-increment) == NUM_VECTORS: go to DONE, pass <= (no mismatch this run, including this vector). Otherwise go to SETTLE.
- Latency:
  - Each vector takes 2 cycles.
  - done rises 2*NUM_VECTORS cycles after the start edge.
  - done stays high until rst or a new start.
- In DONE, a_out/b_out hold their advanced values; the DUT output is not checked.

Test Plan:
- Defaults with a correct adder, start pulse:
  - Vector 0 drives a=28, b=5 and expects 33.
  - Vector 1 drives a=30, b=5 and expects 35.
  - Vector 2 drives a=0, b=8 and expects 8 (a wraps).
  - done asserts 100 cycles after start with pass=1, err_count=0, vec_count=50.
- Faulty DUT model returning sum+1 only when a=0, b=8 -> pass=0, err_count equals the number of (0,8) vectors in the run, first_err_a=0, first_err_b=8, first_err_sum=9.
- DUT model stuck at 0 with NUM_VECTORS=300 -> err_count saturates at 255 (no wrap), pass=0, first_err captured at vector 0 (a=28, b=5, sum=0).
- Carry check, N=5, A_INIT=31, B_INIT=31, NUM_VECTORS=1, correct DUT -> golden=62 (MSB set), pass=1, done 2 cycles after start.
- start pulsed again at cycle 10 of a run -> ignored, with vec_count continuing normally. rst asserted at cycle 20 -> next cycle IDLE with all outputs at reset values.
- start pulsed in DONE -> counters and first_err_* cleared, a_out=28, b_out=5, second run completes identically to the first.
